// File: rtl/dtw_stream_core.sv
// dtw_stream_core: streaming dynamic-time-warping datapath with one PE per
// query sample. The query is loaded once, then reference samples flow through
// the PE chain. The array computes either global DTW or subsequence DTW.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse; accepted in IDLE or DONE only
//   mode_sub, qry_len   run configuration, sampled on an accepted start
//   q_valid/q_ready     query sample stream (q_data)
//   ref_valid/ref_ready reference sample stream (ref_data, ref_last)
//   busy, done, cfg_err status: busy in LOAD/RUN/DRAIN, done held in DONE,
//                       cfg_err pulses when start carries an illegal qry_len
//   minval, minpos      minimum of the last query row and its 1-based column
//   endval              final-corner cost D(qry_len, ref_count)
//   ref_count           reference samples accepted (saturating)
//
// Handshake rule for both streams: a sample transfers on a rising clk edge
// where valid and ready are both high. Ready depends only on the FSM state,
// and the source may assert valid regardless of ready.
module dtw_stream_core #(
    parameter int WIDTH    = 16,
    parameter int SQG_SIZE = 256,
    parameter int QLW      = $clog2(SQG_SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_sub,
    input  logic [QLW-1:0]   qry_len,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [WIDTH-1:0] q_data,
    input  logic             ref_valid,
    output logic             ref_ready,
    input  logic [WIDTH-1:0] ref_data,
    input  logic             ref_last,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [WIDTH-1:0] minval,
    output logic [31:0]      minpos,
    output logic [WIDTH-1:0] endval,
    output logic [31:0]      ref_count
);
    localparam logic [WIDTH-1:0] INF  = '1;
    localparam logic [31:0]      CMAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [QLW-1:0]   len_r, q_idx;
    logic             sub_r, first_r;
    logic [31:0]      out_cnt;
    logic [WIDTH-1:0] x_r   [1:SQG_SIZE];
    logic [WIDTH-1:0] y_r   [0:SQG_SIZE-1];
    logic             tag_r [0:SQG_SIZE];
    logic [WIDTH-1:0] d_r   [1:SQG_SIZE];
    logic [WIDTH-1:0] dp_r  [1:SQG_SIZE-1];
    logic [WIDTH-1:0] d_new [1:SQG_SIZE];

    logic idle_like, len_ok, start_ok, start_bad, q_fire, inject, collect;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign len_ok    = (qry_len != '0) && (qry_len <= QLW'(SQG_SIZE));
    assign start_ok  = start && idle_like && len_ok;
    assign start_bad = start && idle_like && !len_ok;
    assign q_ready   = (state == S_LOAD);
    assign ref_ready = (state == S_RUN);
    assign busy      = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign q_fire    = q_valid && q_ready;
    assign inject    = ref_valid && ref_ready;
    assign collect   = busy && tag_r[len_r];

    // Saturating |x-y| + min(n, w, nw); all-ones behaves as infinity.
    function automatic logic [WIDTH-1:0] cell_cost(
        input logic [WIDTH-1:0] x, y, n, w, nw);
        logic [WIDTH-1:0] ad, m;
        logic [WIDTH:0]   s;
        ad = (x >= y) ? (x - y) : (y - x);
        m  = n;
        if (w < m)  m = w;
        if (nw < m) m = nw;
        s = {1'b0, ad} + {1'b0, m};
        cell_cost = (s >= {1'b0, INF}) ? INF : s[WIDTH-1:0];
    endfunction

    // PE k sees column j on the stage-(k-1) register, while PE k-1 holds
    // D(k-1,j) in d_r and D(k-1,j-1) in dp_r.
    for (genvar k = 1; k <= SQG_SIZE; k++) begin : g_pe
        logic [WIDTH-1:0] n_in, nw_in;
        if (k == 1) begin : g_first
            // Virtual row 0: zero everywhere for sDTW; for global DTW, only the
            // diagonal into column 1 is zero.
            assign n_in  = sub_r ? '0 : INF;
            assign nw_in = (sub_r || first_r) ? '0 : INF;
        end else begin : g_rest
            assign n_in  = d_r[k-1];
            assign nw_in = dp_r[k-1];
        end
        assign d_new[k] = cell_cost(x_r[k], y_r[k-1], n_in, d_r[k], nw_in);
    end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            for (int k = 0; k <= SQG_SIZE; k++) tag_r[k] <= 1'b0;
            for (int k = 1; k <= SQG_SIZE; k++) d_r[k] <= INF;
            for (int k = 1; k < SQG_SIZE; k++)  dp_r[k] <= INF;
        end else begin
            tag_r[0] <= inject;
            for (int k = 1; k <= SQG_SIZE; k++) begin
                tag_r[k] <= tag_r[k-1];
                if (tag_r[k-1]) d_r[k] <= d_new[k];
            end
            for (int k = 1; k < SQG_SIZE; k++)
                if (tag_r[k-1]) dp_r[k] <= d_r[k];
        end
    end

    // Sample data paths carry no reset; the tags decide what is meaningful.
    always_ff @(posedge clk) begin
        y_r[0] <= ref_data;
        for (int k = 1; k < SQG_SIZE; k++) y_r[k] <= y_r[k-1];
        if (q_fire) x_r[q_idx] <= q_data;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start_ok) state_nx = S_LOAD;
            S_LOAD:  if (q_fire && q_idx == len_r) state_nx = S_RUN;
            S_RUN:   if (inject && ref_last) state_nx = S_DRAIN;
            S_DRAIN: if (out_cnt == ref_count) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_r     <= QLW'(1);
            sub_r     <= 1'b0;
            q_idx     <= QLW'(1);
            first_r   <= 1'b0;
            ref_count <= '0;
            out_cnt   <= '0;
            minval    <= INF;
            minpos    <= '0;
            endval    <= INF;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= start_bad;
            if (start_ok) begin
                len_r     <= qry_len;
                sub_r     <= mode_sub;
                q_idx     <= QLW'(1);
                first_r   <= 1'b1;
                ref_count <= '0;
                out_cnt   <= '0;
                minval    <= INF;
                minpos    <= '0;
                endval    <= INF;
            end else begin
                if (q_fire) q_idx <= q_idx + 1'b1;
                if (tag_r[0]) first_r <= 1'b0;
                if (inject && ref_count != CMAX) ref_count <= ref_count + 32'd1;
                if (collect) begin
                    endval <= d_r[len_r];
                    if (d_r[len_r] < minval) begin
                        minval <= d_r[len_r];
                        minpos <= (out_cnt == CMAX) ? CMAX : out_cnt + 32'd1;
                    end
                    if (out_cnt != CMAX) out_cnt <= out_cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dtw_stream_core.sv
module tb_dtw_stream_core;
    localparam int WIDTH = 16;
    localparam int SQG   = 8;
    localparam int QLW   = $clog2(SQG + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mode_sub = 1'b0;
    logic [QLW-1:0]   qry_len = '0;
    logic             q_valid = 1'b0;
    logic             q_ready;
    logic [WIDTH-1:0] q_data = '0;
    logic             ref_valid = 1'b0;
    logic             ref_ready;
    logic [WIDTH-1:0] ref_data = '0;
    logic             ref_last = 1'b0;
    logic             busy, done, cfg_err;
    logic [WIDTH-1:0] minval, endval;
    logic [31:0]      minpos, ref_count;

    int n_tests = 0;
    int n_fail  = 0;
    // {endval, minval, minpos, ref_count}
    logic [95:0]      exp_q[$];
    logic [WIDTH-1:0] q_vec[$];
    logic [WIDTH-1:0] r_vec[$];
    logic             done_q = 1'b0;

    dtw_stream_core #(.WIDTH(WIDTH), .SQG_SIZE(SQG)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_sub(mode_sub),
        .qry_len(qry_len), .q_valid(q_valid), .q_ready(q_ready),
        .q_data(q_data), .ref_valid(ref_valid), .ref_ready(ref_ready),
        .ref_data(ref_data), .ref_last(ref_last), .busy(busy), .done(done),
        .cfg_err(cfg_err), .minval(minval), .minpos(minpos),
        .endval(endval), .ref_count(ref_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // scoreboard monitor: one result per rising edge of done
    always @(negedge clk) begin
        if (!rst && done && !done_q) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done rose with empty expected queue");
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("endval",    {16'd0, endval}, {16'd0, e[95:80]});
                check("minval",    {16'd0, minval}, {16'd0, e[79:64]});
                check("minpos",    minpos,    e[63:32]);
                check("ref_count", ref_count, e[31:0]);
            end
        end
        done_q = done;
    end

    // driver tasks
    task automatic do_start(input logic m, input logic [QLW-1:0] len);
        @(negedge clk);
        start = 1'b1; mode_sub = m; qry_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_q(input logic [WIDTH-1:0] v);
        int b = 0;
        @(negedge clk);
        q_valid = 1'b1; q_data = v;
        while (!q_ready && b < 50) begin @(negedge clk); b++; end
        if (!q_ready) begin
            n_tests++; n_fail++;
            $display("FAIL q_handshake_timeout: q_ready=%0d required 1", q_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_ref(input logic [WIDTH-1:0] v, input logic last);
        int b = 0;
        @(negedge clk);
        ref_valid = 1'b1; ref_data = v; ref_last = last;
        while (!ref_ready && b < 50) begin @(negedge clk); b++; end
        if (!ref_ready) begin
            n_tests++; n_fail++;
            $display("FAIL ref_handshake_timeout: ref_ready=%0d required 1", ref_ready);
        end
        @(posedge clk);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin @(negedge clk); c++; end
        check("done_within_budget", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_q_ready"},   {31'd0, q_ready},   32'd0);
        check({tag, "_ref_ready"}, {31'd0, ref_ready}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_done"},      {31'd0, done},      32'd0);
        check({tag, "_cfg_err"},   {31'd0, cfg_err},   32'd0);
        check({tag, "_minval"},    {16'd0, minval},    32'h0000_FFFF);
        check({tag, "_minpos"},    minpos,             32'd0);
        check({tag, "_endval"},    {16'd0, endval},    32'h0000_FFFF);
        check({tag, "_ref_count"}, ref_count,          32'd0);
    endtask

    // Full run from q_vec/r_vec; expected result goes to the scoreboard.
    task automatic run_case(input logic m, input logic [QLW-1:0] len, input bit gaps,
                            input logic [95:0] e, input bit timing, input bit chk_clear);
        exp_q.push_back(e);
        do_start(m, len);
        check("q_ready_in_load",   {31'd0, q_ready},   32'd1);
        check("ref_ready_in_load", {31'd0, ref_ready}, 32'd0);
        if (chk_clear) begin
            check("restart_done",      {31'd0, done},   32'd0);
            check("restart_minval",    {16'd0, minval}, 32'h0000_FFFF);
            check("restart_minpos",    minpos,          32'd0);
            check("restart_endval",    {16'd0, endval}, 32'h0000_FFFF);
            check("restart_ref_count", ref_count,       32'd0);
        end
        for (int i = 0; i < q_vec.size(); i++) begin
            send_q(q_vec[i]);
            if (gaps && i != q_vec.size() - 1) begin
                @(negedge clk); q_valid = 1'b0;
                @(negedge clk);
            end
        end
        @(negedge clk); q_valid = 1'b0;
        for (int i = 0; i < r_vec.size(); i++) begin
            send_ref(r_vec[i], i == r_vec.size() - 1);
            if (gaps && i != r_vec.size() - 1) begin
                @(negedge clk); ref_valid = 1'b0;
                @(negedge clk);
            end
        end
        @(negedge clk);
        ref_valid = 1'b0; ref_last = 1'b0;
        check("ref_ready_after_last", {31'd0, ref_ready}, 32'd0);
        if (timing) begin
            repeat (4) @(negedge clk);
            check("done_not_before_e0_plus_5", {31'd0, done}, 32'd0);
            @(negedge clk);
            check("done_at_e0_plus_5", {31'd0, done}, 32'd1);
        end
        wait_done(200);
    endtask

    task automatic set_test1_data();
        q_vec = '{16'd1, 16'd2, 16'd3};
        r_vec = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd9};
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        // illegal lengths stay in IDLE and pulse cfg_err
        do_start(1'b0, QLW'(0));
        check("cfg_err_len0", {31'd0, cfg_err}, 32'd1);
        check("idle_len0",    {31'd0, busy},    32'd0);
        @(negedge clk);
        check("cfg_err_pulse_len0", {31'd0, cfg_err}, 32'd0);
        do_start(1'b0, QLW'(SQG + 1));
        check("cfg_err_len_max1", {31'd0, cfg_err}, 32'd1);
        check("idle_len_max1",    {31'd0, q_ready}, 32'd0);
        @(negedge clk);
        check("cfg_err_pulse_len_max1", {31'd0, cfg_err}, 32'd0);

        // test 1: global DTW with done timing
        set_test1_data();
        run_case(1'b0, QLW'(3), 1'b0, {16'd7, 16'd1, 32'd4, 32'd5}, 1'b1, 1'b0);
        // test 2: subsequence DTW
        run_case(1'b1, QLW'(3), 1'b0, {16'd6, 16'd0, 32'd4, 32'd5}, 1'b0, 1'b0);
        // test 3: same with bubbles and query gaps
        run_case(1'b1, QLW'(3), 1'b1, {16'd6, 16'd0, 32'd4, 32'd5}, 1'b0, 1'b0);
        // restart from DONE clears results, then a fresh global run
        run_case(1'b0, QLW'(3), 1'b0, {16'd7, 16'd1, 32'd4, 32'd5}, 1'b0, 1'b1);
        // test 4: saturation
        q_vec = '{16'd0};
        r_vec = '{16'hFFFF, 16'hFFFF};
        run_case(1'b0, QLW'(1), 1'b0, {16'hFFFF, 16'hFFFF, 32'd0, 32'd2}, 1'b0, 1'b0);

        // test 6: reset in the middle of RUN
        set_test1_data();
        do_start(1'b0, QLW'(3));
        for (int i = 0; i < 3; i++) send_q(q_vec[i]);
        @(negedge clk); q_valid = 1'b0;
        send_ref(16'd0, 1'b0);
        send_ref(16'd1, 1'b0);
        @(negedge clk);
        check("mid_run_ref_count", ref_count, 32'd2);
        ref_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("mid_reset");
        run_case(1'b0, QLW'(3), 1'b0, {16'd7, 16'd1, 32'd4, 32'd5}, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
